// File: rtl/btn_led_pio_pkg.sv
// btn_led_pio_pkg: register map, button level and reset constants shared by
// the button/LED PIO peripheral and its debouncer.
package btn_led_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_LEDS    = 2'd1,
    ADDR_EDGE    = 2'd2,
    ADDR_IRQMASK = 2'd3
  } reg_addr_e;

  localparam logic        BTN_RELEASED = 1'b1;

  localparam logic        RST_SYNC     = 1'b1;
  localparam logic        RST_BTN_DB   = BTN_RELEASED;
  localparam logic        RST_EDGE     = 1'b0;
  localparam logic        RST_IRQMASK  = 1'b0;
  localparam logic        RST_IRQ      = 1'b0;
  localparam logic [31:0] RST_READDATA = '0;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser followed by a stable-count debouncer.
// The output level only follows the synchronised sample after it has
// differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
  import btn_led_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          sample;
  logic [CW-1:0] cnt_q;

  assign sample = sync_q[1];

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync_q <= {2{RST_SYNC}};
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Count consecutive disagreeing samples; accept the new level on the last one.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cnt_q <= '0;
      level <= RST_BTN_DB;
    end else if (sample == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      level <= sample;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/btn_led_pio.sv
// btn_led_pio: Avalon-MM button/LED peripheral. Registers: DATA (debounced
// button), LEDS, EDGE (press capture, write-1-clear), IRQMASK.
// Optional feature macro: BTN_IRQ_EN adds the registered irq output.
module btn_led_pio
  import btn_led_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LED_WIDTH       = 4
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic [31:0]          avs_readdata,
  input  logic                 btn_external_connection_export,
  output logic [LED_WIDTH-1:0] leds_external_connection_export
`ifdef BTN_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic                 btn_db;
  logic                 btn_db_q;
  logic                 press;
  logic                 edge_q;
  logic                 edge_vis;
  logic                 edge_clr;
  logic [LED_WIDTH-1:0] leds_q;
  logic                 mask_q;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .raw        (btn_external_connection_export),
    .level      (btn_db)
  );

  // The debouncer only exposes its level, so a press is seen one cycle late
  // against btn_db_q. OR-ing that pulse into the visible EDGE value makes it
  // read as set from the same edge btn_db falls, and the pulse lands in
  // edge_q on the next edge, so a clear coinciding with the fall never wins.
  assign press    = (btn_db_q == BTN_RELEASED) && (btn_db != BTN_RELEASED);
  assign edge_vis = edge_q | press;
  assign edge_clr = avs_write && (reg_addr_e'(avs_address) == ADDR_EDGE)
                    && avs_writedata[0];

  assign leds_external_connection_export = leds_q;
  assign unused_wdata = ^avs_writedata;

  // Press capture with write-1-clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      btn_db_q <= RST_BTN_DB;
      edge_q   <= RST_EDGE;
    end else begin
      btn_db_q <= btn_db;
      edge_q   <= edge_vis & ~edge_clr;
    end
  end

  // Software-writable LEDS and IRQMASK registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      leds_q <= '0;
      mask_q <= RST_IRQMASK;
    end else if (avs_write) begin
      case (reg_addr_e'(avs_address))
        ADDR_LEDS:    leds_q <= avs_writedata[LED_WIDTH-1:0];
        ADDR_IRQMASK: mask_q <= avs_writedata[0];
        default:      ;
      endcase
    end
  end

  // Read mux of the pre-write register values; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (reg_addr_e'(avs_address))
      ADDR_DATA:    rd_mux[0]             = btn_db;
      ADDR_LEDS:    rd_mux[LED_WIDTH-1:0] = leds_q;
      ADDR_EDGE:    rd_mux[0]             = edge_vis;
      ADDR_IRQMASK: rd_mux[0]             = mask_q;
      default:      rd_mux                = '0;
    endcase
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= RST_READDATA;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

`ifdef BTN_IRQ_EN
  // Level interrupt: captured press gated by the mask, one cycle behind.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irq <= RST_IRQ;
    end else begin
      irq <= edge_vis & mask_q;
    end
  end
`endif

endmodule

// File: tb/tb_btn_led_pio.sv
// tb_btn_led_pio: directed test-plan scenarios plus randomized bus/button
// traffic, checked against a window-based behavioural model of the peripheral.
module tb_btn_led_pio;

  localparam int unsigned DB = 4;
  localparam int unsigned LW = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          btn;
  logic [LW-1:0] leds;
  logic          irq;

  int unsigned checks = 0;
  int unsigned errors = 0;

  btn_led_pio #(
    .DEBOUNCE_CYCLES(DB),
    .LED_WIDTH      (LW)
  ) dut (
`ifdef BTN_IRQ_EN
    .irq                            (irq),
`endif
    .clk_clk                        (clk),
    .reset_reset                    (rst),
    .avs_address                    (avs_address),
    .avs_read                       (avs_read),
    .avs_write                      (avs_write),
    .avs_writedata                  (avs_writedata),
    .avs_readdata                   (avs_readdata),
    .btn_external_connection_export (btn),
    .leds_external_connection_export(leds)
  );

`ifndef BTN_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw button history per clock edge; the debounced level
  // flips once the DB raw values seen two edges earlier all disagree with it.
  logic          hist [0:DB+1];
  logic          m_db;
  logic          m_edge;
  logic          m_mask;
  logic          m_irq;
  logic [LW-1:0] m_leds;
  logic [31:0]   m_rdata;
  logic [31:0]   m_rv;
  logic          m_flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DB + 1; i++) hist[i] = 1'b1;
      m_db = 1'b1; m_edge = 1'b0; m_mask = 1'b0; m_irq = 1'b0;
      m_leds = '0; m_rdata = '0;
    end else begin
      m_rv = '0;
      case (avs_address)
        2'd0: m_rv[0] = m_db;
        2'd1: m_rv[LW-1:0] = m_leds;
        2'd2: m_rv[0] = m_edge;
        default: m_rv[0] = m_mask;
      endcase
      if (avs_read) m_rdata = m_rv;
      m_irq = m_edge & m_mask;
      if (avs_write) begin
        if (avs_address == 2'd1) m_leds = avs_writedata[LW-1:0];
        if (avs_address == 2'd3) m_mask = avs_writedata[0];
        if (avs_address == 2'd2 && avs_writedata[0]) m_edge = 1'b0;
      end
      for (int i = DB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
      m_flip = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (hist[i] == m_db) m_flip = 1'b0;
      if (m_flip) begin
        m_db = ~m_db;
        if (!m_db) m_edge = 1'b1;
      end
    end
  end

  // Continuous comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("readdata", avs_readdata, m_rdata);
      check_eq("leds", {{(32-LW){1'b0}}, leds}, {{(32-LW){1'b0}}, m_leds});
`ifdef BTN_IRQ_EN
      check_eq("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      avs_read = 1'b0;
      avs_write = 1'b0;
    end
  endtask

  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1; avs_write = 1'b0;
    @(negedge clk);
    avs_read = 1'b0;
    check_eq(tag, avs_readdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1; avs_read = 1'b0;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; btn = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", avs_readdata, 32'h0);
    check_eq("rst_leds", {28'b0, leds}, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    bus_read("rd_data", 2'd0, 32'h1);
    bus_read("rd_leds", 2'd1, 32'h0);
    bus_read("rd_edge", 2'd2, 32'h0);
    bus_read("rd_mask", 2'd3, 32'h0);
    check_eq("pins_init", {28'b0, leds}, 32'h0);

    bus_write(2'd1, 32'h0000000A);
    check_eq("pins_a", {28'b0, leds}, 32'hA);
    bus_write(2'd1, 32'hFFFFFFF5);
    check_eq("pins_5", {28'b0, leds}, 32'h5);
    bus_read("rd_leds5", 2'd1, 32'h5);

    // Glitch of 3 cycles is rejected.
    @(negedge clk); btn = 1'b0;
    idle(2);
    @(negedge clk); btn = 1'b1;
    idle(6);
    bus_read("glitch_data", 2'd0, 32'h1);
    bus_read("glitch_edge", 2'd2, 32'h0);

    // Long press is accepted and captured.
    @(negedge clk); btn = 1'b0;
    idle(10);
    bus_read("press_data", 2'd0, 32'h0);
    bus_read("press_edge", 2'd2, 32'h1);
    bus_write(2'd2, 32'h0);
    bus_read("w0_edge", 2'd2, 32'h1);
    bus_write(2'd2, 32'h1);
    bus_read("w1c_edge", 2'd2, 32'h0);
    @(negedge clk); btn = 1'b1;
    idle(10);
    bus_read("rel_data", 2'd0, 32'h1);
    bus_read("rel_edge", 2'd2, 32'h0);

    // Masked press: irq one cycle behind EDGE, then set beats a coincident clear.
    bus_write(2'd3, 32'h1);
    @(negedge clk); btn = 1'b0;
    idle(5);
    @(negedge clk);
`ifdef BTN_IRQ_EN
    check_eq("irq_lag", {31'b0, irq}, 32'h0);
`endif
    @(negedge clk);
`ifdef BTN_IRQ_EN
    check_eq("irq_rise", {31'b0, irq}, 32'h1);
`endif
    @(negedge clk); btn = 1'b1;
    idle(10);
    @(negedge clk); btn = 1'b0;
    idle(4);
    @(negedge clk);
    avs_address = 2'd2; avs_writedata = 32'h1; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
`ifdef BTN_IRQ_EN
    check_eq("irq_hold", {31'b0, irq}, 32'h1);
`endif
    idle(2);
    bus_read("setwins_edge", 2'd2, 32'h1);
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'h0);
    bus_read("clr_edge", 2'd2, 32'h0);
    @(negedge clk); btn = 1'b1;
    idle(10);

    // Reset while the press is two debounced cycles in.
    bus_write(2'd1, 32'h3);
    @(negedge clk); btn = 1'b0;
    idle(3);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; avs_address = 2'd0; avs_read = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_eq("rst_press", avs_readdata, (k <= 2 + DB) ? 32'h1 : 32'h0);
    end
    avs_read = 1'b0;
    bus_read("rst_leds", 2'd1, 32'h0);
    @(negedge clk); btn = 1'b1;
    idle(10);

    // Randomized traffic; the monitor compares every cycle.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      avs_address   = 2'($urandom_range(0, 3));
      avs_read      = 1'($urandom_range(0, 1));
      avs_write     = ($urandom_range(0, 3) == 0);
      avs_writedata = $urandom;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_led_pio.md
# btn_led_pio

Avalon-MM slave peripheral on the Nios II system bus; the processor-side responder for the button and LED pins of the board top level. It synchronises and debounces the push-button input, captures press events, and optionally raises an interrupt. It also holds the LED output register driven onto the board pins. Software reads the button and writes the LEDs through four word-addressed registers.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles required to accept a new button level (10 ms at 50 MHz).
- `LED_WIDTH`, default 4: LED register and pin width, 1..32.

- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered.
- `btn_external_connection_export`  in  1  raw button, active-low (0 = pressed), asynchronous to `clk_clk`.
- `leds_external_connection_export`  out  LED_WIDTH  LED drive, from the LEDS register.
- `irq`  out  1  interrupt request, level, active-high. Present only with `BTN_IRQ_EN`.

## Operation
- Input path: 2-flop synchroniser feeds the debouncer, which feeds the debounced level `btn_db`.
- Debouncer:
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever the synchronised sample equals `btn_db`.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, `btn_db` takes the sample and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes `btn_db`.
- Press event: a 1→0 transition of `btn_db` sets EDGE[0]. A 0→1 transition (release) has no effect.
- Register map (unused bits read 0; writes to read-only fields ignored):
  - 0 DATA: [0] = `btn_db` (1 = released). Read-only.
  - 1 LEDS: [LED_WIDTH-1:0], read/write.
  - 2 EDGE: [0] = press captured. Writing 1 to bit 0 clears it; writing 0 has no effect.
  - 3 IRQMASK: [0], read/write. The register exists even without `BTN_IRQ_EN`.
- Simultaneous EDGE set and write-1-clear in the same cycle: the set wins and EDGE[0] stays 1.
- `avs_read` and `avs_write` asserted together: the write is performed, and readdata returns the pre-write value.
- Reset values:
  - `btn_db` = 1, synchroniser flops = 1, debounce counter = 0.
  - LEDS = 0, EDGE = 0, IRQMASK = 0.
  - `avs_readdata` = 0, `irq` = 0.
- Reset asserted mid-debounce: the counter and `btn_db` return to their reset values, and a pending transition is discarded.

## Timing
- Fixed read latency of 1: `avs_readdata` is valid the cycle after `avs_read` is sampled high. It holds its value until the next read. No waitrequest.
- Writes take effect at the sampling edge and are visible on outputs the following cycle. An LEDS write reaches the pins 1 cycle after `avs_write`.
- Button-to-`btn_db` latency: 2 synchroniser cycles plus `DEBOUNCE_CYCLES` cycles of a stable sample.
- EDGE[0] sets on the same edge that `btn_db` falls.
- `irq` = EDGE[0] & IRQMASK[0], registered: it asserts 1 cycle after both are high. It deasserts 1 cycle after either clears.
- Back-to-back transactions are supported every cycle.

## Configuration
- `BTN_IRQ_EN` defined: the `irq` port and its register exist, as described in Timing.
- `BTN_IRQ_EN` undefined: no `irq` port and no IRQ logic. IRQMASK remains readable and writable but has no effect. Software polls EDGE.

## Structure
- Package `btn_led_pio_pkg` holds:
  - register address constants `ADDR_DATA=0`, `ADDR_LEDS=1`, `ADDR_EDGE=2`, `ADDR_IRQMASK=3`;
  - the `BTN_RELEASED=1'b1` level constant;
  - reset-value constants.
- Sub-module `btn_debounce`: synchroniser plus stable-count debouncer. Parameter `DEBOUNCE_CYCLES`. Ports `clk_clk`, `reset_reset`, `raw`, `level`.
- Top module: register file, edge detect, readdata mux, IRQ.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LED_WIDTH`=4.
- Reset released → read each of addresses 0..3 → readdata 0x1, 0x0, 0x0, 0x0 one cycle after each read; LED pins 0x0.
- Write 0xA to LEDS → LED pins = 0xA one cycle later. Then write 0xFFFFFFF5 → pins 0x5, and a LEDS readback returns 0x5.
- Button held 0 for 3 cycles then back to 1 → DATA stays 0x1 and EDGE stays 0. Button held 0 for 10 cycles → DATA reads 0x0 and EDGE reads 0x1.
- Press captured, then write 0x0 to EDGE → EDGE still 0x1. Write 0x1 → EDGE 0x0. Release the button (held 1 for 10 cycles) → EDGE stays 0x0.
- `BTN_IRQ_EN` defined, IRQMASK=1, press → `irq` rises 1 cycle after EDGE sets. Write 1 to EDGE in the same cycle a new press sets it → EDGE stays 1 and `irq` stays 1.
- Reset pulsed while the button has been low for 2 debounced cycles → DATA reads 0x1 and LEDS 0x0 after reset. A new press needs the full 2+4 cycles.
